// File: rtl/serial_sub_compare.sv
// Bit-serial WIDTH-bit subtractor / magnitude comparator, LSB first, one bit per clock.
// Two half-subtractor stages per bit with ORed borrows; results registered on completion.
module serial_sub_compare #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Difference,
  output logic             Borrow,
  output logic             A_lt_B,
  output logic             A_eq_B,
  output logic             A_gt_B
);

  // state | meaning
  // IDLE  | waiting for start; operands captured on the accepting edge
  // RUN   | one bit per cycle, count 0..WIDTH-1
  // DONE  | one-cycle result-valid pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           state, state_next;
  logic [WIDTH-1:0] sa, sb, sd;
  logic             bin;
  logic [CW-1:0]    count;

  logic             hs1_d, hs1_b, d, hs2_b, bout, last;
  logic [WIDTH-1:0] sd_next;

  assign hs1_d   = sa[0] ^ sb[0];
  assign hs1_b   = ~sa[0] & sb[0];
  assign d       = hs1_d ^ bin;
  assign hs2_b   = ~hs1_d & bin;
  assign bout    = hs1_b | hs2_b;
  assign sd_next = {d, sd[WIDTH-1:1]};
  assign last    = (count == CW'(WIDTH - 1));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa         <= '0;
      sb         <= '0;
      sd         <= '0;
      bin        <= 1'b0;
      count      <= '0;
      Difference <= '0;
      Borrow     <= 1'b0;
      A_lt_B     <= 1'b0;
      A_eq_B     <= 1'b0;
      A_gt_B     <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        sa    <= A;
        sb    <= B;
        sd    <= '0;
        bin   <= 1'b0;
        count <= '0;
      end else if (state == RUN) begin
        sa    <= {1'b0, sa[WIDTH-1:1]};
        sb    <= {1'b0, sb[WIDTH-1:1]};
        sd    <= sd_next;
        bin   <= bout;
        count <= count + CW'(1);
        // Results are published only here, so they stay frozen while RUN is in progress.
        if (last) begin
          Difference <= sd_next;
          Borrow     <= bout;
          A_lt_B     <= bout;
          A_eq_B     <= ~bout & (sd_next == '0);
          A_gt_B     <= ~bout & (sd_next != '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_sub_compare.sv
// Directed bench for serial_sub_compare: expected results queued at start, checked at done.
module tb_serial_sub_compare;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [W-1:0] A, B;
  logic         busy, done;
  logic [W-1:0] diff;
  logic         brw, lt, eq, gt;

  typedef struct {
    logic [W-1:0] diff;
    logic         brw, lt, eq, gt;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  serial_sub_compare #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Difference(diff), .Borrow(brw),
    .A_lt_B(lt), .A_eq_B(eq), .A_gt_B(gt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.diff = a - b;
    e.brw  = (a < b);
    e.lt   = (a < b);
    e.eq   = (a == b);
    e.gt   = (a > b);
    return e;
  endfunction

  // Called just after an edge in IDLE; returns in the first RUN cycle.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    A = a;
    B = b;
    sb.push_back(model(a, b));
    tick();
    start = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_outs"}, {diff, brw, lt, eq, gt}, 0);
  endtask

  // n0: cycles already elapsed since the accepting edge (or previous done).
  task automatic wait_done(input int n0, input int exp_n, input int exp_busy);
    int n;
    int bc;
    int hold;
    logic [W+3:0] snap;
    n = n0;
    bc = 0;
    hold = 0;
    snap = {diff, brw, lt, eq, gt};
    while (!done && n < 40) begin
      if (busy) bc++;
      if ({diff, brw, lt, eq, gt} !== snap) hold++;
      tick();
      n++;
    end
    check("latency", n, exp_n);
    check("busy_cycles", bc, exp_busy);
    check("outputs_held", hold, 0);
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("difference", diff, e.diff);
      check("borrow", brw, e.brw);
      check("a_lt_b", lt, e.lt);
      check("a_eq_b", eq, e.eq);
      check("a_gt_b", gt, e.gt);
    end else begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end
  endtask

  task automatic after_done();
    tick();
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    int dones;
    rst_n = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    #23;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_zero("post_reset_idle");

    start_op(8'd200, 8'd55);
    wait_done(1, W + 1, W);
    after_done();

    start_op(8'd55, 8'd200);
    wait_done(1, W + 1, W);
    after_done();

    start_op(8'hA5, 8'hA5);
    wait_done(1, W + 1, W);
    after_done();

    start_op(8'h00, 8'h01);
    wait_done(1, W + 1, W);
    after_done();

    // Second start during RUN must be ignored.
    start_op(8'd10, 8'd3);
    tick();
    tick();
    start = 1'b1;
    A = 8'd1;
    B = 8'd2;
    tick();
    start = 1'b0;
    wait_done(4, W + 1, W - 3);
    after_done();
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dones++;
      tick();
    end
    check("no_extra_done", dones, 0);

    // Reset during the 4th RUN cycle.
    start_op(8'd100, 8'd1);
    tick();
    tick();
    tick();
    check("run4_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_zero("mid_run_reset");
    void'(sb.pop_back());
    tick();
    check_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done || busy) dones++;
    end
    check("no_done_after_abort", dones, 0);
    start_op(8'd3, 8'd3);
    wait_done(1, W + 1, W);
    after_done();

    // start held high: back-to-back operations every W+2 cycles.
    start = 1'b1;
    A = 8'd9;
    B = 8'd4;
    for (int i = 0; i < 3; i++) sb.push_back(model(8'd9, 8'd4));
    tick();
    wait_done(1, W + 1, W);
    for (int k = 1; k < 3; k++) begin
      if (k == 2) begin
        tick();
        wait_done(1, W + 2, W);
        start = 1'b0;
      end else begin
        tick();
        wait_done(1, W + 2, W);
      end
    end
    after_done();
    tick();
    check("held_start_stopped", busy, 0);
    check("queue_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
